// File: rtl/aclk_pkg.sv
// Shared types and keymap for the alarm-clock keypad scanner.
// Key codes: 0-9 digits, A/B/C/D letters, then * and #.
package aclk_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    REL_DB
  } scan_state_t;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // nibble {row,col}: r0=1 2 3 A, r1=4 5 6 B, r2=7 8 9 C, r3=* 0 # D
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  function automatic logic single_low(
    input logic [3:0] row_code
  );
    logic [3:0] l;
    l = ~row_code;
    return (l != 4'h0) && ((l & (l - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [3:0] keymap(
    input logic [3:0] row_code,
    input logic [1:0] col
  );
    logic [1:0] r;
    int         idx;
    case (row_code)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    idx = int'({r, col});
    return KEYMAP[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/aclk_keypad_scanner_if.sv
// User-input bundle from the keypad scanner to the clock core.
// master drives the events, slave consumes them.
interface aclk_keypad_scanner_if;
  logic [3:0] key;
  logic       key_strobe;
  logic       time_button;
  logic       alarm_button;
  logic       stopwatch;

  modport master (
    output key,
    output key_strobe,
    output time_button,
    output alarm_button,
    output stopwatch
  );

  modport slave (
    input key,
    input key_strobe,
    input time_button,
    input alarm_button,
    input stopwatch
  );
endinterface

// File: rtl/aclk_sync2.sv
// 4-bit two-flop synchronizer for the asynchronous row lines.
// Resets to all-ones, i.e. "no key pressed".
module aclk_sync2
  import aclk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aclk_keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Emits digit strobes, time/alarm pulses and the stopwatch level.
module aclk_keypad_scanner
  import aclk_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            rows,
  output logic [3:0]            cols,
  aclk_keypad_scanner_if.master kp
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] D_DONE = DW'(DEBOUNCE);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  scan_state_t   state, state_n;
  logic [TW-1:0] tick;
  logic [DW-1:0] db, db_n, db_inc;
  logic [1:0]    col, col_n;
  logic [3:0]    code, code_n;
  logic [3:0]    key, key_n;
  logic          strobe, strobe_n;
  logic          time_q, time_n;
  logic          alarm_q, alarm_n;
  logic          sw, sw_n;
  logic [3:0]    rows_s;
  logic [3:0]    hit;
  logic          sample;
  logic          all_high;

  aclk_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign sample   = (tick == T_LAST);
  assign all_high = (rows_s == 4'hF);
  assign hit      = keymap(code, col);
  assign db_inc   = db + D_ONE;
  assign cols     = ~(4'b0001 << col);

  assign kp.key          = key;
  assign kp.key_strobe   = strobe;
  assign kp.time_button  = time_q;
  assign kp.alarm_button = alarm_q;
  assign kp.stopwatch    = sw;

  // free-running dwell timer; sample point is its last cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= '0;
    end else if (sample) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SCAN;
      db      <= '0;
      col     <= 2'd0;
      code    <= 4'hF;
      key     <= 4'h0;
      strobe  <= 1'b0;
      time_q  <= 1'b0;
      alarm_q <= 1'b0;
      sw      <= 1'b0;
    end else begin
      state   <= state_n;
      db      <= db_n;
      col     <= col_n;
      code    <= code_n;
      key     <= key_n;
      strobe  <= strobe_n;
      time_q  <= time_n;
      alarm_q <= alarm_n;
      sw      <= sw_n;
    end
  end

  always_comb begin
    state_n  = state;
    db_n     = db;
    col_n    = col;
    code_n   = code;
    key_n    = key;
    strobe_n = 1'b0;
    time_n   = 1'b0;
    alarm_n  = 1'b0;
    sw_n     = sw;
    if (sample) begin
      unique case (state)
        SCAN: begin
          if (single_low(rows_s)) begin
            code_n  = rows_s;
            db_n    = D_ONE;
            state_n = PRESS_DB;
          end else begin
            col_n = col + 2'd1;
          end
        end
        PRESS_DB: begin
          if (rows_s != code) begin
            db_n    = '0;
            col_n   = col + 2'd1;
            state_n = SCAN;
          end else if (db_inc == D_DONE) begin
            db_n    = db_inc;
            state_n = HELD;
            unique case (1'b1)
              (hit <= 4'd9): begin
                key_n    = hit;
                strobe_n = 1'b1;
              end
              (hit == KEY_A): time_n  = 1'b1;
              (hit == KEY_B): alarm_n = 1'b1;
              (hit == KEY_C): sw_n    = 1'b1;
              default: ;
            endcase
          end else begin
            db_n = db_inc;
          end
        end
        HELD: begin
          if (all_high) begin
            db_n    = D_ONE;
            state_n = REL_DB;
          end
        end
        REL_DB: begin
          if (!all_high) begin
            db_n    = '0;
            state_n = HELD;
          end else if (db_inc == D_DONE) begin
            db_n    = '0;
            sw_n    = 1'b0;
            col_n   = col + 2'd1;
            state_n = SCAN;
          end else begin
            db_n = db_inc;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Scoreboard bench for aclk_keypad_scanner with a 4x4 keypad model.
// Expected events are queued at press time and matched on output.
module tb_aclk_keypad_scanner;

  localparam int K_DIGIT = 0;
  localparam int K_TIME  = 1;
  localparam int K_ALARM = 2;
  localparam int K_SW_UP = 3;
  localparam int K_SW_DN = 4;

  typedef struct {
    int kind;
    int val;
    int at;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] pressed = '0;
  int          n_pass = 0;
  int          n_chk = 0;
  int          cyc = 0;
  int          det = -100;
  logic        rotating = 1'b0;
  logic [3:0]  dwell_cols = 4'b1110;
  logic        sw_q = 1'b0;
  ev_t         sb[$];

  aclk_keypad_scanner_if kp ();

  aclk_keypad_scanner #(
    .SCAN_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rows  (rows),
    .cols  (cols),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // key (r,c) pulls row r low while column c is driven low
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic got_ev(int kind, int val);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", kind, -1);
    end else begin
      e = sb.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_val", val, e.val);
      if (e.at >= 0) check("ev_at", cyc, e.at);
      else           check("ev_latency", cyc - det, 9);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      rotating   = 1'b0;
      dwell_cols = 4'b1110;
      sw_q       = 1'b0;
    end else begin
      // a column that fails to advance at a dwell start marks detection
      if (cyc % 4 == 0 && cyc > 0) begin
        if (cols != dwell_cols) begin
          rotating = 1'b1;
        end else if (rotating) begin
          det      = cyc - 1;
          rotating = 1'b0;
        end
        dwell_cols = cols;
      end
      if (int'(kp.key_strobe) + int'(kp.time_button)
          + int'(kp.alarm_button) > 1)
        check("one_pulse", int'(kp.key_strobe) + int'(kp.time_button)
              + int'(kp.alarm_button), 1);
      if (kp.key_strobe)   got_ev(K_DIGIT, int'(kp.key));
      if (kp.time_button)  got_ev(K_TIME, 0);
      if (kp.alarm_button) got_ev(K_ALARM, 0);
      if (kp.stopwatch && !sw_q) got_ev(K_SW_UP, 0);
      if (!kp.stopwatch && sw_q) got_ev(K_SW_DN, 0);
      sw_q = kp.stopwatch;
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int idx, int kind, int val, int hold);
    int r;
    sb.push_back('{kind, val, -1});
    @(negedge clk);
    pressed[idx] = 1'b1;
    idle(hold);
    pressed[idx] = 1'b0;
    if (kind == K_SW_UP) begin
      r = cyc + 2;
      while (r % 4 != 3) r++;
      sb.push_back('{K_SW_DN, 0, r + 9});
    end
    idle(40);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_cols"}, int'(cols), 4'b1110);
    check({tag, "_key"}, int'(kp.key), 0);
    check({tag, "_sw"}, int'(kp.stopwatch), 0);
    check({tag, "_strobe"}, int'(kp.key_strobe), 0);
    check({tag, "_time"}, int'(kp.time_button), 0);
    check({tag, "_alarm"}, int'(kp.alarm_button), 0);
  endtask

  initial begin
    logic [3:0] c0;
    #2 reset = 1'b0;
    idle(3);
    check_reset_outputs("rst");
    reset = 1'b1;
    idle(10);

    // single digit 5 held for 200 cycles
    press(5, K_DIGIT, 5, 200);
    check("digit_key", int'(kp.key), 5);
    check("digit_sb", sb.size(), 0);

    // bouncing key 7
    for (int i = 0; i < 4; i++) begin
      pressed[8] = 1'b1;
      idle(5);
      pressed[8] = 1'b0;
      idle(5);
    end
    idle(30);
    c0 = cols;
    idle(4);
    check("bounce_scan", int'(cols != c0), 1);
    check("bounce_key", int'(kp.key), 5);
    check("bounce_sb", sb.size(), 0);

    // time-button entry: A 2 3 5 5 A
    press(3, K_TIME, 0, 60);
    press(1, K_DIGIT, 2, 60);
    press(2, K_DIGIT, 3, 60);
    press(5, K_DIGIT, 5, 60);
    press(5, K_DIGIT, 5, 60);
    press(3, K_TIME, 0, 60);
    check("entry_key", int'(kp.key), 5);
    check("entry_sb", sb.size(), 0);

    // stopwatch: hold C
    press(11, K_SW_UP, 0, 100);
    check("sw_key", int'(kp.key), 5);
    check("sw_level", int'(kp.stopwatch), 0);
    check("sw_sb", sb.size(), 0);

    // 2 and 8 together share column 1: invalid
    @(negedge clk);
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    idle(60);
    pressed = '0;
    idle(40);
    check("dbl_key", int'(kp.key), 5);
    check("dbl_sb", sb.size(), 0);

    // B then reset while held
    sb.push_back('{K_ALARM, 0, -1});
    @(negedge clk);
    pressed[7] = 1'b1;
    idle(50);
    check("b_sb", sb.size(), 0);
    reset = 1'b0;
    idle(2);
    check_reset_outputs("midrst");
    pressed = '0;
    idle(3);
    reset = 1'b1;
    idle(1);
    check_reset_outputs("postrst");
    idle(40);
    check("post_key", int'(kp.key), 0);
    check("final_sb", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
